mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction and data ports share one downstream memory port.
// Data requests win ties unless the instruction port has waited STARVE_LIMIT grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        imem_read,
  input  logic        imem_write,
  input  logic [31:0] imem_address,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_byte_enable,
  input  logic        imem_stall,
  output logic        imem_resp,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,

  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_enable,
  input  logic        dmem_stall,
  output logic        dmem_resp,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,

  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StServeI,
    StServeD,
    StDoneI,
    StDoneD
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic        op_read_q, op_write_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] imem_rdata_q, dmem_rdata_q;

  logic imem_req, dmem_req;
  logic grant, grant_dmem;
  logic sel_read, sel_write;
  logic [31:0] sel_address, sel_wdata;
  logic [3:0]  sel_be;

  assign imem_req = (imem_read | imem_write) & ~imem_stall;
  assign dmem_req = (dmem_read | dmem_write) & ~dmem_stall;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant      = 1'b0;
    grant_dmem = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dmem_req && !(imem_req && starve_q == Limit)) begin
          state_d    = StServeD;
          grant      = 1'b1;
          grant_dmem = 1'b1;
          // The guard above keeps starve_q below Limit here, so this saturates.
          if (imem_req) starve_d = starve_q + 1'b1;
        end else if (imem_req) begin
          state_d  = StServeI;
          grant    = 1'b1;
          starve_d = '0;
        end
      end
      StServeI: if (mem_resp) state_d = StDoneI;
      StServeD: if (mem_resp) state_d = StDoneD;
      StDoneI:  state_d = StIdle;
      StDoneD:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Read and write together is treated as a write.
  always_comb begin
    if (grant_dmem) begin
      sel_read    = dmem_read & ~dmem_write;
      sel_write   = dmem_write;
      sel_address = dmem_address;
      sel_wdata   = dmem_wdata;
      sel_be      = dmem_byte_enable;
    end else begin
      sel_read    = imem_read & ~imem_write;
      sel_write   = imem_write;
      sel_address = imem_address;
      sel_wdata   = imem_wdata;
      sel_be      = imem_byte_enable;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_read_q  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else if (grant) begin
      op_read_q  <= sel_read;
      op_write_q <= sel_write;
      addr_q     <= sel_address;
      wdata_q    <= sel_wdata;
      be_q       <= sel_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
    end else if (mem_resp && op_read_q) begin
      if (state_q == StServeI) imem_rdata_q <= mem_rdata;
      if (state_q == StServeD) dmem_rdata_q <= mem_rdata;
    end
  end

  logic serving;
  assign serving = (state_q == StServeI) || (state_q == StServeD);

  assign mem_read        = serving & op_read_q;
  assign mem_write       = serving & op_write_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_byte_enable = be_q;

  assign imem_resp  = ~imem_req | (state_q == StDoneI);
  assign dmem_resp  = ~dmem_req | (state_q == StDoneD);
  assign imem_ready = (state_q == StDoneI) & op_read_q;
  assign dmem_ready = (state_q == StDoneD) & op_read_q;
  assign imem_rdata = imem_rdata_q;
  assign dmem_rdata = dmem_rdata_q;

endmodule
